// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed parallel-to-serial transmitter (start, LSB-first data, optional parity, stop)
module serial_frame_tx #(
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_d,
  output logic              o_busy,
  output logic              o_done
);
  localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [IW-1:0] idx, idx_n;
  logic [TW-1:0] timer, timer_n;
  logic par, par_n, d_n, done_n, tick, accept;
  assign tick = timer == '0;
  assign o_ready = (state == IDLE) & ~i_rst;
  assign accept = i_valid & o_ready;
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n = idx;
    par_n = par;
    done_n = 1'b0;
    timer_n = tick ? RELOAD : timer - TW'(1);
    case (state)
      IDLE: begin
        timer_n = '0;
        if (accept) begin
          state_n = START;
          shreg_n = i_data;
          idx_n = '0;
          timer_n = RELOAD;
          par_n = PARITY_ODD != 0 ? ~^i_data : ^i_data;
        end
      end
      START: state_n = tick ? DATA : START;
      DATA: if (tick) begin
        if (idx == LAST) state_n = PARITY_EN != 0 ? PARITY : STOP;
        else begin
          idx_n = idx + IW'(1);
          shreg_n = shreg >> 1;
        end
      end
      PARITY: state_n = tick ? STOP : PARITY;
      STOP: if (tick) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    d_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      shreg <= '0;
      idx <= '0;
      timer <= '0;
      par <= 1'b0;
      o_d <= 1'b1;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      idx <= idx_n;
      timer <= timer_n;
      par <= par_n;
      o_d <= d_n;
      o_busy <= state_n != IDLE;
      o_done <= done_n;
    end
  end
endmodule
